// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - shared types and constants for the four-phase bundled-data sender
package handshake_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    REQ_HI = 2'd2,
    REQ_LO = 2'd3
  } state_e;

  // Wide enough to hold the saturated value TIMEOUT itself.
  function automatic int tcnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/ack_sync.sv
// rtl/ack_sync.sv - multi-flop synchroniser for a single asynchronous handshake line
module ack_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic q_out
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_in};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q[STAGES-1];

endmodule

// File: rtl/handshake_sender.sv
// rtl/handshake_sender.sv - clocked valid/ready to four-phase request/ack bundled-data initiator
module handshake_sender
  import handshake_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int SETUP_CYCLES = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT      = 64,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] src_data,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             request_out,
  input  logic             ack_in,
  output logic             busy,
  output logic [CNT_W-1:0] sent_count,
  output logic             timeout_err
);

  localparam int             TW         = tcnt_width(TIMEOUT);
  localparam logic [TW-1:0]  TCNT_MAX   = TW'(TIMEOUT);
  localparam logic [TW-1:0]  TCNT_ERR   = TW'(TIMEOUT - 1);
  localparam logic [3:0]     SETUP_INIT = 4'(SETUP_CYCLES - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               req_q, req_d;
  logic [3:0]         scnt_q, scnt_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [CNT_W-1:0]   sent_q, sent_d;
  logic               err_q, err_d;
  logic               ack_s;
  logic               waiting;

  ack_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d_in  (ack_in),
    .q_out (ack_s)
  );

  // A stale ack still visible in IDLE must clear before a new word may start.
  assign src_ready = (state_q == IDLE) && !ack_s;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    scnt_d  = scnt_q;
    tcnt_d  = tcnt_q;
    sent_d  = sent_q;
    err_d   = err_q;
    waiting = (state_q == REQ_HI) || (state_q == REQ_LO);

    if (waiting && (tcnt_q != TCNT_MAX)) begin
      tcnt_d = tcnt_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        if (src_valid && src_ready) begin
          data_d  = src_data;
          scnt_d  = SETUP_INIT;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (scnt_q == 4'd0) begin
          req_d   = 1'b1;
          tcnt_d  = '0;
          state_d = REQ_HI;
        end else begin
          scnt_d = scnt_q - 4'd1;
        end
      end
      REQ_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          tcnt_d  = '0;
          state_d = REQ_LO;
        end else if (tcnt_q >= TCNT_ERR) begin
          err_d = 1'b1;
        end
      end
      REQ_LO: begin
        // Timeout only flags; the word is never dropped or retried.
        if (!ack_s) begin
          sent_d  = sent_q + CNT_W'(1);
          state_d = IDLE;
        end else if (tcnt_q >= TCNT_ERR) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      req_q   <= 1'b0;
      scnt_q  <= '0;
      tcnt_q  <= '0;
      sent_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      req_q   <= req_d;
      scnt_q  <= scnt_d;
      tcnt_q  <= tcnt_d;
      sent_q  <= sent_d;
      err_q   <= err_d;
    end
  end

  assign data_out    = data_q;
  assign request_out = req_q;
  assign busy        = (state_q != IDLE);
  assign sent_count  = sent_q;
  assign timeout_err = err_q;

endmodule
